// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time controller.
package reaction_pkg;

  localparam int RT_W = 14;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    TIMING = 3'd2,
    DONE   = 3'd3,
    EARLY  = 3'd4
  } state_t;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts enabled cycles and pulses tick on the last
// cycle of every CYCLES_PER_MS-cycle period.
module ms_tick_gen #(
  parameter int CYCLES_PER_MS = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_MS - 1);

  logic [CW-1:0] cnt_reg;

  // tick is decoded from the count so the consumer sees it on the same edge
  // that wraps the prescaler.
  assign tick = en && (cnt_reg == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      if (cnt_reg == LAST) cnt_reg <= '0;
      else                 cnt_reg <= cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-time trial controller: waits for the random delay, lights the
// lamp, and measures the time to the user's press in milliseconds.
module reaction_ctrl
  import reaction_pkg::*;
#(
  parameter int CYCLES_PER_MS = 100000,
  parameter int MAX_MS        = 9999
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_btn,
  input  logic            stop_btn,
  input  logic            wait5_done,
  output logic            start_wait5,
  output logic            led_on,
  output logic [RT_W-1:0] rt_ms,
  output logic            rt_valid,
  output logic            early,
  output logic            timeout
);

  localparam logic [RT_W-1:0] MAX_V = RT_W'(MAX_MS);

  state_t          state_reg;
  logic [RT_W-1:0] ms_cnt_reg;
  logic [RT_W-1:0] ms_next;
  logic            max_hit;
  logic            tick;
  logic            in_timing;

  assign in_timing = (state_reg == TIMING);

  // Prescaler is held clear outside TIMING so every timing phase starts at 0.
  ms_tick_gen #(
    .CYCLES_PER_MS(CYCLES_PER_MS)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (!in_timing),
    .en  (in_timing),
    .tick(tick)
  );

  always_comb begin
    ms_next = ms_cnt_reg;
    max_hit = 1'b0;
    if (tick && (ms_cnt_reg != MAX_V)) begin
      ms_next = ms_cnt_reg + RT_W'(1);
    end
    if (ms_next == MAX_V) begin
      max_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      start_wait5 <= 1'b0;
      led_on      <= 1'b0;
      rt_ms       <= '0;
      rt_valid    <= 1'b0;
      early       <= 1'b0;
      timeout     <= 1'b0;
      ms_cnt_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE, EARLY: begin
          if (start_btn) begin
            state_reg   <= WAIT;
            start_wait5 <= 1'b1;
            rt_ms       <= '0;
            rt_valid    <= 1'b0;
            early       <= 1'b0;
            timeout     <= 1'b0;
          end
        end
        WAIT: begin
          // A press during the delay beats a coincident delay-done.
          if (stop_btn) begin
            state_reg   <= EARLY;
            start_wait5 <= 1'b0;
            led_on      <= 1'b0;
            early       <= 1'b1;
          end else if (wait5_done) begin
            state_reg   <= TIMING;
            start_wait5 <= 1'b0;
            led_on      <= 1'b1;
            ms_cnt_reg  <= '0;
          end
        end
        TIMING: begin
          if (stop_btn) begin
            state_reg <= DONE;
            led_on    <= 1'b0;
            rt_ms     <= ms_next;
            rt_valid  <= 1'b1;
          end else if (max_hit) begin
            state_reg <= DONE;
            led_on    <= 1'b0;
            rt_ms     <= MAX_V;
            rt_valid  <= 1'b1;
            timeout   <= 1'b1;
          end
          ms_cnt_reg <= ms_next;
        end
        default: begin
          state_reg   <= IDLE;
          start_wait5 <= 1'b0;
          led_on      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_ctrl.sv
// Directed bench for reaction_ctrl with CYCLES_PER_MS=4, MAX_MS=20.
module tb_reaction_ctrl;
  import reaction_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start_btn = 1'b0;
  logic            stop_btn = 1'b0;
  logic            wait5_done = 1'b0;
  logic            start_wait5;
  logic            led_on;
  logic [RT_W-1:0] rt_ms;
  logic            rt_valid;
  logic            early;
  logic            timeout;

  int checks = 0;
  int errors = 0;

  reaction_ctrl #(
    .CYCLES_PER_MS(4),
    .MAX_MS       (20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_btn  (start_btn),
    .stop_btn   (stop_btn),
    .wait5_done (wait5_done),
    .start_wait5(start_wait5),
    .led_on     (led_on),
    .rt_ms      (rt_ms),
    .rt_valid   (rt_valid),
    .early      (early),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-22s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_outs(input string tag, input logic sw, input logic led,
                            input int ms, input logic v, input logic e, input logic t);
    check({tag, ".start_wait5"}, 32'(start_wait5), 32'(sw));
    check({tag, ".led_on"},      32'(led_on),      32'(led));
    check({tag, ".rt_ms"},       32'(rt_ms),       32'(ms));
    check({tag, ".rt_valid"},    32'(rt_valid),    32'(v));
    check({tag, ".early"},       32'(early),       32'(e));
    check({tag, ".timeout"},     32'(timeout),     32'(t));
  endtask

  task automatic check_state(input string tag, input state_t exp);
    check({tag, ".state"}, 32'(dut.state_reg), 32'(exp));
  endtask

  task automatic pulse_start();
    start_btn = 1'b1; cyc(1); start_btn = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_btn = 1'b1; cyc(1); stop_btn = 1'b0;
  endtask

  // Enters WAIT, then TIMING after 10 cycles; returns just after TIMING entry.
  task automatic enter_timing();
    pulse_start();
    cyc(9);
    wait5_done = 1'b1; cyc(1); wait5_done = 1'b0;
  endtask

  initial begin
    // Reset
    cyc(1);
    rst = 1'b1; cyc(2); rst = 1'b0;
    check_outs("reset", 0, 0, 0, 0, 0, 0);
    check_state("reset", IDLE);

    // wait5_done in IDLE is ignored
    wait5_done = 1'b1; cyc(1); wait5_done = 1'b0;
    check_state("idle_w5", IDLE);

    // Normal trial
    pulse_start();
    check_outs("wait", 1, 0, 0, 0, 0, 0);
    cyc(9);
    check("wait_hold.start_wait5", 32'(start_wait5), 32'd1);
    wait5_done = 1'b1; cyc(1); wait5_done = 1'b0;
    check_outs("timing", 0, 1, 0, 0, 0, 0);
    check_state("timing", TIMING);
    cyc(29);
    pulse_stop();
    check_outs("normal", 0, 0, 7, 1, 0, 0);
    check_state("normal", DONE);
    wait5_done = 1'b1; cyc(3); wait5_done = 1'b0;
    check_outs("done_hold", 0, 0, 7, 1, 0, 0);

    // Early press
    pulse_start();
    check_outs("restart", 1, 0, 0, 0, 0, 0);
    cyc(2);
    pulse_stop();
    check_outs("early", 0, 0, 0, 0, 1, 0);
    check_state("early", EARLY);

    // Timeout, with a start_btn ignored mid-TIMING
    enter_timing();
    cyc(9);
    pulse_start();
    check_state("timing_start", TIMING);
    check("timing_start.led_on", 32'(led_on), 32'd1);
    cyc(69);
    check_outs("pre_timeout", 0, 1, 0, 0, 0, 0);
    cyc(1);
    check_outs("timeout", 0, 0, 20, 1, 0, 1);
    check_state("timeout", DONE);

    // Stop coinciding with the MAX_MS edge
    enter_timing();
    cyc(79);
    pulse_stop();
    check_outs("stop_at_max", 0, 0, 20, 1, 0, 0);

    // stop_btn and wait5_done together in WAIT
    pulse_start();
    cyc(2);
    stop_btn = 1'b1; wait5_done = 1'b1; cyc(1);
    stop_btn = 1'b0; wait5_done = 1'b0;
    check_outs("simul", 0, 0, 0, 0, 1, 0);
    check_state("simul", EARLY);
    cyc(3);
    check("simul_hold.led_on", 32'(led_on), 32'd0);

    // Reset mid-WAIT
    pulse_start();
    cyc(2);
    rst = 1'b1; cyc(1); rst = 1'b0;
    check_outs("rst_wait", 0, 0, 0, 0, 0, 0);
    check_state("rst_wait", IDLE);

    // Reset mid-TIMING, then a clean trial
    enter_timing();
    cyc(10);
    rst = 1'b1; stop_btn = 1'b1; cyc(1); rst = 1'b0; stop_btn = 1'b0;
    check_outs("rst_timing", 0, 0, 0, 0, 0, 0);
    check_state("rst_timing", IDLE);
    check("rst_timing.ms_cnt", 32'(dut.ms_cnt_reg), 32'd0);
    enter_timing();
    cyc(5);
    pulse_stop();
    check_outs("clean", 0, 0, 1, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
